// File: rtl/ddr3_test_pkg.sv
// Shared types for the DDR3 pattern tester: FSM state encoding and pattern modes.
package ddr3_test_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_WR_ISSUE    = 4'd1,
    ST_WR_WAIT     = 4'd2,
    ST_WR_REF      = 4'd3,
    ST_WR_REF_WAIT = 4'd4,
    ST_RD_ISSUE    = 4'd5,
    ST_RD_WAIT     = 4'd6,
    ST_RD_REF      = 4'd7,
    ST_RD_REF_WAIT = 4'd8,
    ST_DONE        = 4'd9
  } state_e;

  localparam logic [1:0] MODE_ADDR_XOR  = 2'd0;
  localparam logic [1:0] MODE_ADDR_XNOR = 2'd1;
  localparam logic [1:0] MODE_WALK_ONE  = 2'd2;
  localparam logic [1:0] MODE_WALK_ZERO = 2'd3;

endpackage

// File: rtl/ddr3_pattern_gen.sv
// Combinational test-pattern generator: a pure function of word index, mode and seed,
// so the read pass regenerates exactly what the write pass stored.
module ddr3_pattern_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 26
) (
  input  logic [IDX_WIDTH-1:0]  index_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  output logic [DATA_WIDTH-1:0] pattern_o
);
  import ddr3_test_pkg::*;

  logic [DATA_WIDTH-1:0] addr_word;
  logic [DATA_WIDTH-1:0] walk_one;
  logic [31:0]           bit_pos;

  // NOTE: every signal driven in always_comb gets a default first, otherwise a path
  // that skips an assignment infers a latch.
  always_comb begin
    addr_word = DATA_WIDTH'(index_i);
    bit_pos   = 32'(index_i) % 32'(DATA_WIDTH);
    walk_one  = DATA_WIDTH'(1) << bit_pos;
    pattern_o = addr_word ^ seed_i;
    unique case (mode_i)
      MODE_ADDR_XOR:  pattern_o = addr_word ^ seed_i;
      MODE_ADDR_XNOR: pattern_o = ~(addr_word ^ seed_i);
      MODE_WALK_ONE:  pattern_o = walk_one ^ seed_i;
      MODE_WALK_ZERO: pattern_o = ~(walk_one ^ seed_i);
    endcase
  end

endmodule

// File: rtl/ddr3_pattern_tester.sv
// End-to-end DDR3 checker: writes a generated pattern over a word range, reads it back
// through the data_ready handshake, and reports per-lane failures, error count and timeout.
module ddr3_pattern_tester #(
  parameter  int DATA_WIDTH    = 16,
  parameter  int ADDR_WIDTH    = 26,
  parameter  int BASE_ADDR     = 0,
  parameter  int TEST_WORDS    = 262144,
  parameter  int REFRESH_EVERY = 1,
  parameter  int RD_TIMEOUT    = 63,
  localparam int LANES         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  stop_on_fail,
  output logic                  running,
  output logic                  done,
  output logic [3:0]            state,
  output logic [LANES-1:0]      fail_lane,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic                  rd,
  output logic                  wr,
  output logic                  refresh,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] dout,
  input  logic                  data_ready,
  input  logic                  busy
);
  import ddr3_test_pkg::*;

  localparam int RC_W = (REFRESH_EVERY > 1) ? $clog2(REFRESH_EVERY) : 1;
  localparam int TO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
  localparam bit REF_EN = (REFRESH_EVERY != 0);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TEST_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [RC_W-1:0]       REF_LAST = RC_W'(REF_EN ? REFRESH_EVERY - 1 : 0);
  localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(RD_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [RC_W-1:0]       ref_cnt_q, ref_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic                  stop_q, stop_d;
  logic                  running_q, running_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic [LANES-1:0]      fail_lane_q, fail_lane_d;
  logic [15:0]           err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] first_fail_q, first_fail_d;
  logic                  rd_q, rd_d, wr_q, wr_d, refresh_q, refresh_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  logic [DATA_WIDTH-1:0] pattern;
  logic [LANES-1:0]      lane_miss;
  logic                  ref_hit, last_idx;
  logic [ADDR_WIDTH-1:0] adv_idx;
  logic [RC_W-1:0]       ref_cnt_inc;
  state_e                wr_adv_state, rd_adv_state;

  ddr3_pattern_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (ADDR_WIDTH)
  ) u_pattern_gen (
    .index_i  (idx_q),
    .mode_i   (mode_q),
    .seed_i   (seed_q),
    .pattern_o(pattern)
  );

  always_comb begin
    lane_miss = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_miss[l] = (dout[l*8 +: 8] != pattern[l*8 +: 8]);
    end
  end

  always_comb begin
    ref_hit      = REF_EN && (ref_cnt_q == REF_LAST);
    ref_cnt_inc  = REF_EN ? ref_cnt_q + 1'b1 : '0;
    last_idx     = (idx_q == LAST_IDX);
    adv_idx      = last_idx ? '0 : idx_q + 1'b1;
    wr_adv_state = last_idx ? ST_RD_ISSUE : ST_WR_ISSUE;
    rd_adv_state = last_idx ? ST_DONE : ST_RD_ISSUE;

    state_d      = state_q;
    idx_d        = idx_q;
    ref_cnt_d    = ref_cnt_q;
    to_cnt_d     = to_cnt_q;
    mode_d       = mode_q;
    seed_d       = seed_q;
    stop_d       = stop_q;
    running_d    = running_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    fail_lane_d  = fail_lane_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    addr_d       = addr_q;
    din_d        = din_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    refresh_d    = 1'b0;

    // The *_WAIT states ignore busy while their own strobe is still high: the
    // controller only sees the strobe at the end of that cycle.
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_d       = mode;
          seed_d       = seed;
          stop_d       = stop_on_fail;
          fail_lane_d  = '0;
          timeout_d    = 1'b0;
          err_count_d  = '0;
          first_fail_d = '0;
          done_d       = 1'b0;
          running_d    = 1'b1;
          idx_d        = '0;
          ref_cnt_d    = '0;
          state_d      = ST_WR_ISSUE;
        end
      end
      ST_WR_ISSUE: begin
        wr_d    = 1'b1;
        din_d   = pattern;
        addr_d  = BASE + idx_q;
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (!wr_q && !busy) begin
          if (ref_hit) begin
            ref_cnt_d = '0;
            state_d   = ST_WR_REF;
          end else begin
            ref_cnt_d = ref_cnt_inc;
            idx_d     = adv_idx;
            state_d   = wr_adv_state;
          end
        end
      end
      ST_WR_REF: begin
        refresh_d = 1'b1;
        state_d   = ST_WR_REF_WAIT;
      end
      ST_WR_REF_WAIT: begin
        if (!refresh_q && !busy) begin
          idx_d   = adv_idx;
          state_d = wr_adv_state;
        end
      end
      ST_RD_ISSUE: begin
        rd_d     = 1'b1;
        addr_d   = BASE + idx_q;
        to_cnt_d = '0;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (data_ready) begin
          if (|lane_miss) begin
            fail_lane_d = fail_lane_q | lane_miss;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (err_count_q == '0) first_fail_d = addr_q;
          end
          if (|lane_miss && stop_q) begin
            state_d = ST_DONE;
          end else if (ref_hit) begin
            ref_cnt_d = '0;
            state_d   = ST_RD_REF;
          end else begin
            ref_cnt_d = ref_cnt_inc;
            idx_d     = adv_idx;
            state_d   = rd_adv_state;
          end
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_RD_REF: begin
        refresh_d = 1'b1;
        state_d   = ST_RD_REF_WAIT;
      end
      ST_RD_REF_WAIT: begin
        if (!refresh_q && !busy) begin
          idx_d   = adv_idx;
          state_d = rd_adv_state;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE && state_q != ST_DONE) begin
      running_d = 1'b0;
      done_d    = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      ref_cnt_q    <= '0;
      to_cnt_q     <= '0;
      mode_q       <= '0;
      seed_q       <= '0;
      stop_q       <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      fail_lane_q  <= '1;
      err_count_q  <= '0;
      first_fail_q <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      refresh_q    <= 1'b0;
      addr_q       <= BASE;
      din_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ref_cnt_q    <= ref_cnt_d;
      to_cnt_q     <= to_cnt_d;
      mode_q       <= mode_d;
      seed_q       <= seed_d;
      stop_q       <= stop_d;
      running_q    <= running_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      fail_lane_q  <= fail_lane_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      refresh_q    <= refresh_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
    end
  end

  assign state           = state_q;
  assign running         = running_q;
  assign done            = done_q;
  assign timeout         = timeout_q;
  assign fail_lane       = fail_lane_q;
  assign err_count       = err_count_q;
  assign first_fail_addr = first_fail_q;
  assign rd              = rd_q;
  assign wr              = wr_q;
  assign refresh         = refresh_q;
  assign addr            = addr_q;
  assign din             = din_q;

endmodule

// File: tb/tb_ddr3_pattern_tester.sv
// Directed bench: two testers (refresh every access / every 4th) against a simple
// controller model with injectable corruption, dropped reads and slow reads.
`timescale 1ns/1ps
module tb_ddr3_pattern_tester;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic        start_m [2];
  logic [1:0]  mode_m  [2];
  logic [15:0] seed_m  [2];
  logic        stop_m  [2];
  logic        dr_inj;

  logic        running_o [2];
  logic        done_o    [2];
  logic [3:0]  state_o   [2];
  logic [1:0]  fail_o    [2];
  logic        timeout_o [2];
  logic [15:0] err_o     [2];
  logic [7:0]  ffa_o     [2];
  logic        rd_o      [2];
  logic        wr_o      [2];
  logic        ref_o     [2];
  logic [7:0]  addr_o    [2];
  logic [15:0] din_o     [2];

  // controller model state (owned by the model process)
  logic [15:0] mem [2][16];
  logic [15:0] dout_m [2];
  logic        dr_m [2];
  logic        busy_m [2];
  int          busy_cnt [2];
  int          lat_cnt [2];
  logic [3:0]  rd_a [2];
  int          n_wr [2];
  int          n_rd [2];
  int          n_ref [2];
  int          wait_cnt [2];
  int          fault_cyc [2];

  // fault configuration (owned by the stimulus process)
  logic [15:0] flip [2][16];
  int          drop_w [2];
  int          slow_w [2];
  int          slow_lat [2];

  // per-run baselines
  int base_wr, base_rd, base_ref, done_cyc;

  ddr3_pattern_tester #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .BASE_ADDR(0), .TEST_WORDS(16),
    .REFRESH_EVERY(1), .RD_TIMEOUT(63)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start_m[0]), .mode(mode_m[0]), .seed(seed_m[0]),
    .stop_on_fail(stop_m[0]), .running(running_o[0]), .done(done_o[0]), .state(state_o[0]),
    .fail_lane(fail_o[0]), .timeout(timeout_o[0]), .err_count(err_o[0]),
    .first_fail_addr(ffa_o[0]), .rd(rd_o[0]), .wr(wr_o[0]), .refresh(ref_o[0]),
    .addr(addr_o[0]), .din(din_o[0]), .dout(dr_inj ? 16'hA5C3 : dout_m[0]),
    .data_ready(dr_m[0] | dr_inj), .busy(busy_m[0])
  );

  ddr3_pattern_tester #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .BASE_ADDR(0), .TEST_WORDS(16),
    .REFRESH_EVERY(4), .RD_TIMEOUT(63)
  ) dut4 (
    .clk(clk), .resetn(resetn), .start(start_m[1]), .mode(mode_m[1]), .seed(seed_m[1]),
    .stop_on_fail(stop_m[1]), .running(running_o[1]), .done(done_o[1]), .state(state_o[1]),
    .fail_lane(fail_o[1]), .timeout(timeout_o[1]), .err_count(err_o[1]),
    .first_fail_addr(ffa_o[1]), .rd(rd_o[1]), .wr(wr_o[1]), .refresh(ref_o[1]),
    .addr(addr_o[1]), .din(din_o[1]), .dout(dout_m[1]),
    .data_ready(dr_m[1]), .busy(busy_m[1])
  );

  // Controller model: busy for 2 cycles after any strobe, read data 4 cycles after rd.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        busy_cnt[k] = 0;
        lat_cnt[k]  = 0;
        dr_m[k]     = 1'b0;
      end else begin
        dr_m[k] = 1'b0;
        if (busy_cnt[k] != 0) busy_cnt[k]--;
        if (lat_cnt[k] != 0) begin
          lat_cnt[k]--;
          if (lat_cnt[k] == 0) begin
            dr_m[k]   = 1'b1;
            dout_m[k] = mem[k][rd_a[k]] ^ flip[k][rd_a[k]];
            if (flip[k][rd_a[k]] != 16'h0) fault_cyc[k] = cyc;
          end
        end
        if (rd_o[k]) wait_cnt[k] = 1;
        else if (state_o[k] == 4'd6) wait_cnt[k]++;
        if (wr_o[k]) begin
          mem[k][addr_o[k][3:0]] = din_o[k];
          n_wr[k]++;
          busy_cnt[k] = 2;
        end
        if (ref_o[k]) begin
          n_ref[k]++;
          busy_cnt[k] = 2;
        end
        if (rd_o[k]) begin
          n_rd[k]++;
          busy_cnt[k] = 2;
          rd_a[k] = addr_o[k][3:0];
          if (int'(rd_a[k]) == drop_w[k]) lat_cnt[k] = 0;
          else if (int'(rd_a[k]) == slow_w[k]) lat_cnt[k] = slow_lat[k];
          else lat_cnt[k] = 4;
        end
      end
      busy_m[k] = (busy_cnt[k] != 0);
    end
  end

  task automatic clear_faults();
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++) flip[k][w] = 16'h0;
      drop_w[k]   = -1;
      slow_w[k]   = -1;
      slow_lat[k] = 4;
    end
  endtask

  task automatic start_run(input int k, input logic [1:0] md, input logic [15:0] sd,
                           input logic stop);
    @(negedge clk);
    base_wr  = n_wr[k];
    base_rd  = n_rd[k];
    base_ref = n_ref[k];
    mode_m[k]  = md;
    seed_m[k]  = sd;
    stop_m[k]  = stop;
    start_m[k] = 1'b1;
    @(negedge clk);
    start_m[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input string name);
    bit ok = 0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (done_o[k]) ok = 1;
    end
    done_cyc = cyc;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: done not seen within 2000 cycles (state %0d)", name, state_o[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({wr_o[k], rd_o[k], ref_o[k], running_o[k], done_o[k], timeout_o[k]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_flags[%0d]: got %b expected 000000", k,
                 {wr_o[k], rd_o[k], ref_o[k], running_o[k], done_o[k], timeout_o[k]});
      end
      checks++;
      if (fail_o[k] !== 2'b11) begin
        errors++; $display("FAIL reset_fail_lane[%0d]: got %b expected 11", k, fail_o[k]);
      end
      checks++;
      if ({err_o[k], ffa_o[k], addr_o[k], din_o[k], state_o[k]} !== 52'h0) begin
        errors++;
        $display("FAIL reset_regs[%0d]: err %0h ffa %0h addr %0h din %0h state %0d, expected all 0",
                 k, err_o[k], ffa_o[k], addr_o[k], din_o[k], state_o[k]);
      end
    end
  endtask

  task automatic test_pass();
    start_run(0, 2'd0, 16'h67BC, 1'b0);
    wait_done(0, "pass_done");
    checks++;
    if (fail_o[0] !== 2'b00 || err_o[0] !== 16'd0 || timeout_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL pass_status: fail_lane %b err %0d timeout %b expected 00 0 0",
               fail_o[0], err_o[0], timeout_o[0]);
    end
    checks++;
    if (n_wr[0] - base_wr != 16 || n_rd[0] - base_rd != 16) begin
      errors++;
      $display("FAIL pass_strobes: wr %0d rd %0d expected 16 16", n_wr[0] - base_wr, n_rd[0] - base_rd);
    end
    checks++;
    if (n_ref[0] - base_ref != 32) begin
      errors++; $display("FAIL pass_refresh: got %0d expected 32", n_ref[0] - base_ref);
    end
    checks++;
    if (state_o[0] !== 4'd9 || running_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL pass_state: state %0d running %b expected 9 0", state_o[0], running_o[0]);
    end
    checks++;
    if (mem[0][5] !== 16'h67B9) begin
      errors++; $display("FAIL pass_word5: got %h expected 67b9", mem[0][5]);
    end
  endtask

  task automatic test_ignore_data_ready();
    @(negedge clk);
    dr_inj = 1'b1;
    @(negedge clk);
    dr_inj = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (err_o[0] !== 16'd0 || fail_o[0] !== 2'b00 || state_o[0] !== 4'd9) begin
      errors++;
      $display("FAIL idle_data_ready: err %0d fail_lane %b state %0d expected 0 00 9",
               err_o[0], fail_o[0], state_o[0]);
    end
  endtask

  task automatic test_stop_on_fail();
    clear_faults();
    flip[0][5] = 16'h0200;
    start_run(0, 2'd0, 16'h67BC, 1'b1);
    wait_done(0, "stop_done");
    checks++;
    if (fail_o[0] !== 2'b10 || err_o[0] !== 16'd1 || ffa_o[0] !== 8'd5) begin
      errors++;
      $display("FAIL stop_status: fail_lane %b err %0d first_fail %0d expected 10 1 5",
               fail_o[0], err_o[0], ffa_o[0]);
    end
    checks++;
    if (done_cyc - fault_cyc[0] > 20 || done_cyc < fault_cyc[0]) begin
      errors++;
      $display("FAIL stop_latency: done %0d cycles after bad read, expected <= 20",
               done_cyc - fault_cyc[0]);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (n_rd[0] - base_rd != 6) begin
      errors++; $display("FAIL stop_reads: got %0d reads expected 6", n_rd[0] - base_rd);
    end
  endtask

  task automatic test_continue_on_fail();
    clear_faults();
    flip[0][3] = 16'h0101;
    flip[0][7] = 16'h8080;
    start_run(0, 2'd0, 16'h67BC, 1'b0);
    wait_done(0, "cont_done");
    checks++;
    if (fail_o[0] !== 2'b11 || err_o[0] !== 16'd2 || ffa_o[0] !== 8'd3) begin
      errors++;
      $display("FAIL cont_status: fail_lane %b err %0d first_fail %0d expected 11 2 3",
               fail_o[0], err_o[0], ffa_o[0]);
    end
    checks++;
    if (n_rd[0] - base_rd != 16 || timeout_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL cont_reads: reads %0d timeout %b expected 16 0", n_rd[0] - base_rd, timeout_o[0]);
    end
  endtask

  task automatic test_timeout();
    clear_faults();
    drop_w[0] = 2;
    start_run(0, 2'd0, 16'h67BC, 1'b0);
    wait_done(0, "tmo_done");
    checks++;
    if (timeout_o[0] !== 1'b1 || state_o[0] !== 4'd9 || running_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL tmo_status: timeout %b state %0d running %b expected 1 9 0",
               timeout_o[0], state_o[0], running_o[0]);
    end
    checks++;
    if (wait_cnt[0] != 63) begin
      errors++; $display("FAIL tmo_wait_cycles: got %0d expected 63", wait_cnt[0]);
    end
    checks++;
    if (n_rd[0] - base_rd != 3 || err_o[0] !== 16'd0) begin
      errors++;
      $display("FAIL tmo_reads: reads %0d err %0d expected 3 0", n_rd[0] - base_rd, err_o[0]);
    end
  endtask

  task automatic test_timeout_boundary();
    clear_faults();
    slow_w[0]   = 4;
    slow_lat[0] = 62;
    start_run(0, 2'd0, 16'h0F0F, 1'b0);
    wait_done(0, "tmo_edge_done");
    checks++;
    if (timeout_o[0] !== 1'b0 || err_o[0] !== 16'd0 || n_rd[0] - base_rd != 16) begin
      errors++;
      $display("FAIL tmo_edge: timeout %b err %0d reads %0d expected 0 0 16",
               timeout_o[0], err_o[0], n_rd[0] - base_rd);
    end
  endtask

  task automatic test_refresh_walk();
    int bad = 0;
    logic [15:0] exp;
    clear_faults();
    start_run(1, 2'd2, 16'h67BC, 1'b0);
    wait_done(1, "walk_done");
    checks++;
    if (n_ref[1] - base_ref != 8 || n_wr[1] - base_wr != 16) begin
      errors++;
      $display("FAIL walk_refresh: refresh %0d wr %0d expected 8 16",
               n_ref[1] - base_ref, n_wr[1] - base_wr);
    end
    checks++;
    if (mem[1][9] !== 16'h65BC) begin
      errors++; $display("FAIL walk_word9: got %h expected 65bc", mem[1][9]);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (16'h1 << i) ^ 16'h67BC;
      if (mem[1][i] !== exp) bad++;
    end
    checks++;
    if (bad != 0 || err_o[1] !== 16'd0 || fail_o[1] !== 2'b00) begin
      errors++;
      $display("FAIL walk_data: bad words %0d err %0d fail_lane %b expected 0 0 00",
               bad, err_o[1], fail_o[1]);
    end
  endtask

  task automatic test_modes();
    int bad = 0;
    logic [15:0] exp;
    clear_faults();
    start_run(0, 2'd1, 16'h1234, 1'b0);
    wait_done(0, "xnor_done");
    checks++;
    if (mem[0][9] !== 16'hEDC2 || err_o[0] !== 16'd0) begin
      errors++; $display("FAIL xnor_word9: got %h err %0d expected edc2 0", mem[0][9], err_o[0]);
    end
    start_run(0, 2'd3, 16'h0F0F, 1'b0);
    wait_done(0, "walk0_done");
    for (int i = 0; i < 16; i++) begin
      exp = ~((16'h1 << i) ^ 16'h0F0F);
      if (mem[0][i] !== exp) bad++;
    end
    checks++;
    if (bad != 0 || mem[0][4] !== 16'hF0E0 || err_o[0] !== 16'd0) begin
      errors++;
      $display("FAIL walk0_data: bad words %0d word4 %h err %0d expected 0 f0e0 0",
               bad, mem[0][4], err_o[0]);
    end
  endtask

  task automatic test_back_to_back();
    clear_faults();
    start_run(0, 2'd0, 16'h1111, 1'b0);
    repeat (20) @(negedge clk);
    start_m[0] = 1'b1;
    @(negedge clk);
    start_m[0] = 1'b0;
    wait_done(0, "b2b_first_done");
    checks++;
    if (n_wr[0] - base_wr != 16 || err_o[0] !== 16'd0) begin
      errors++;
      $display("FAIL b2b_ignore_start: wr %0d err %0d expected 16 0", n_wr[0] - base_wr, err_o[0]);
    end
    start_run(0, 2'd0, 16'h2222, 1'b0);
    checks++;
    if (done_o[0] !== 1'b0 || running_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: done %b running %b expected 0 1", done_o[0], running_o[0]);
    end
    wait_done(0, "b2b_second_done");
    checks++;
    if (mem[0][15] !== 16'h222D || err_o[0] !== 16'd0 || fail_o[0] !== 2'b00) begin
      errors++;
      $display("FAIL b2b_second: word15 %h err %0d fail_lane %b expected 222d 0 00",
               mem[0][15], err_o[0], fail_o[0]);
    end
  endtask

  task automatic test_reset_midrun();
    int strobes = 0;
    clear_faults();
    start_run(0, 2'd0, 16'h67BC, 1'b0);
    repeat (40) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({wr_o[0], rd_o[0], ref_o[0], running_o[0]} !== 4'b0 || state_o[0] !== 4'd0) begin
      errors++;
      $display("FAIL midrun_reset_async: strobes/running %b state %0d expected 0000 0",
               {wr_o[0], rd_o[0], ref_o[0], running_o[0]}, state_o[0]);
    end
    checks++;
    if (fail_o[0] !== 2'b11 || addr_o[0] !== 8'd0 || din_o[0] !== 16'd0 || err_o[0] !== 16'd0) begin
      errors++;
      $display("FAIL midrun_reset_regs: fail_lane %b addr %0h din %0h err %0d expected 11 0 0 0",
               fail_o[0], addr_o[0], din_o[0], err_o[0]);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (wr_o[0] || rd_o[0] || ref_o[0]) strobes++;
    end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    if (wr_o[0] || rd_o[0] || ref_o[0]) strobes++;
    checks++;
    if (strobes != 0 || fail_o[0] !== 2'b11 || done_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrun_post_reset: strobe cycles %0d fail_lane %b done %b expected 0 11 0",
               strobes, fail_o[0], done_o[0]);
    end
    start_run(0, 2'd0, 16'h67BC, 1'b0);
    wait_done(0, "midrun_rerun_done");
    checks++;
    if (err_o[0] !== 16'd0 || fail_o[0] !== 2'b00 || n_rd[0] - base_rd != 16) begin
      errors++;
      $display("FAIL midrun_rerun: err %0d fail_lane %b reads %0d expected 0 00 16",
               err_o[0], fail_o[0], n_rd[0] - base_rd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dr_inj = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_m[k] = 1'b0;
      mode_m[k]  = 2'd0;
      seed_m[k]  = 16'h0;
      stop_m[k]  = 1'b0;
    end
    clear_faults();
    repeat (3) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    test_pass();
    test_ignore_data_ready();
    test_stop_on_fail();
    test_continue_on_fail();
    test_timeout();
    test_timeout_boundary();
    test_refresh_walk();
    test_modes();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_pattern_tester.md
# ddr3_pattern_tester

Parametrised end-to-end memory checker that sits between the top-level test/debug logic and an already-initialised `ddr3_controller`. It writes a generated pattern over a configurable word range, then reads every word back and compares it per byte lane. Read completion is handshake-driven via `data_ready` with a timeout, not a fixed latency. It adds selectable patterns, configurable refresh interleave, a saturating error count, first-failure capture and an optional continue-on-fail mode.

## Interface
- `DATA_WIDTH`, 16: controller data width; multiple of 8; `LANES = DATA_WIDTH/8`
- `ADDR_WIDTH`, 26: controller address width
- `BASE_ADDR`, 0: first word address tested
- `TEST_WORDS`, 262144: words per pass; ≥2; `BASE_ADDR+TEST_WORDS` ≤ 2^ADDR_WIDTH
- `REFRESH_EVERY`, 1: issue one refresh after every N accesses; 0 disables refresh
- `RD_TIMEOUT`, 63: max cycles in RD_WAIT without `data_ready`
- `clk`  in  1  system clock (pclk or divided pclk)
- `resetn`  in  1  reset; one clock; asynchronous, active-low
- `start`  in  1  pulse; starts a run from IDLE or DONE; ignored while running
- `mode`  in  2  pattern select, sampled at start
- `seed`  in  DATA_WIDTH  pattern seed, sampled at start
- `stop_on_fail`  in  1  1: stop at first mismatch; sampled at start
- `running`  out  1  run in progress
- `done`  out  1  run finished (pass, fail or timeout); held until next start
- `state`  out  4  FSM state code
- `fail_lane`  out  LANES  sticky per-byte-lane mismatch
- `timeout`  out  1  sticky read timeout
- `err_count`  out  16  mismatched words, saturates at 16'hFFFF
- `first_fail_addr`  out  ADDR_WIDTH  address of first mismatch
- `rd`, `wr`, `refresh`  out  1 each  single-cycle controller strobes
- `addr`  out  ADDR_WIDTH  controller address
- `din`  out  DATA_WIDTH  write data
- `dout`  in  DATA_WIDTH  read data
- `data_ready`  in  1  read data valid pulse
- `busy`  in  1  controller busy

## Operation
- Reset values: strobes 0, running 0, done 0, timeout 0, `fail_lane` all ones (fail until a run starts), err_count 0, first_fail_addr 0, addr = BASE_ADDR, din 0, state IDLE.
- Index `i` = 0..TEST_WORDS-1; `addr = BASE_ADDR + i`; `A` = `i` zero-extended/truncated to DATA_WIDTH.
- Patterns:
  - 0: `A ^ seed`
  - 1: `~(A ^ seed)`
  - 2: walking one, bit `i mod DATA_WIDTH` set, XOR seed
  - 3: walking zero, inverse of mode 2
- The pattern is a pure function of `i`, so the read pass regenerates it.
- States (codes):
  - IDLE 0, WR_ISSUE 1, WR_WAIT 2, WR_REF 3, WR_REF_WAIT 4
  - RD_ISSUE 5, RD_WAIT 6, RD_REF 7, RD_REF_WAIT 8, DONE 9
- IDLE/DONE + start:
  - clear fail_lane, timeout, err_count, first_fail_addr and done; set running
  - set `i` = 0, refresh counter = 0; go to WR_ISSUE
- WR_ISSUE: pulse `wr` with `din` = pattern(i); go to WR_WAIT.
- WR_WAIT: leave when `busy` = 0, no earlier than the cycle after the strobe.
  - If the refresh counter hits REFRESH_EVERY-1 (and REFRESH_EVERY ≠ 0), go to WR_REF and clear the counter.
  - Otherwise increment the counter and advance.
- Advance from the write pass: last `i` → `i` = 0, RD_ISSUE; else `i`+1 → WR_ISSUE.
- WR_REF pulses `refresh`. WR_REF_WAIT waits for `busy` = 0 with the same one-cycle rule, then advances.
- RD_ISSUE: pulse `rd`, clear the timeout counter; go to RD_WAIT.
- RD_WAIT: on `data_ready`, compare `dout` against pattern(i) per lane.
  - Set mismatching `fail_lane` bits and increment `err_count` (saturating).
  - Capture `first_fail_addr` on the first mismatch only.
  - Mismatch with stop_on_fail=1 → DONE. Otherwise apply the refresh-counter rule (RD_REF/RD_REF_WAIT) and advance: last `i` → DONE, else RD_ISSUE.
- RD_WAIT timeout: if the counter reaches RD_TIMEOUT with no `data_ready`, set `timeout`, then DONE.
- Entering DONE: running ← 0, done ← 1.
- `data_ready` outside RD_WAIT is ignored.

## Timing
- Strobes are registered and high for exactly one cycle.
- `din` and `addr` are valid in the strobe cycle and held until the next issue.
- Minimum cost per access is 3 cycles (issue, wait ≥1, advance).
- Comparison occurs in the `data_ready` cycle; error outputs update the following cycle.
- `data_ready` in the same cycle as the timeout limit counts as data (no timeout).
- Asynchronous reset mid-run forces reset values immediately. No controller strobe is issued after reset asserts.

## Structure
- Package `ddr3_test_pkg`: state enum (4-bit codes above), pattern mode constants.
- Sub-module `ddr3_pattern_gen`: combinational; inputs index, mode, seed; output DATA_WIDTH pattern. Parametrised by DATA_WIDTH.

## Test plan
- Ideal controller model (busy 2 cycles, data_ready 4 cycles after rd), TEST_WORDS=16, mode 0, seed 16'h67BC → done=1, fail_lane=2'b00, err_count=0, 32 wr+rd strobes, 32 refreshes.
- Model corrupts bit 9 of word 5, stop_on_fail=1 → fail_lane=2'b10, err_count=1, first_fail_addr=5, done within 20 cycles of that read, no further rd.
- Same fault on words 3 and 7, both lanes, stop_on_fail=0 → all 16 reads done, err_count=2, first_fail_addr=3, fail_lane=2'b11.
- Model never returns data_ready for word 2, RD_TIMEOUT=63 → timeout=1 after 63 RD_WAIT cycles, done=1, state=9.
- REFRESH_EVERY=4, mode 2 → exactly 8 refresh pulses total; din of write i equals (1<<(i%16))^seed.
- Reset pulsed mid write pass, then start → outputs return to reset values, fail_lane=all ones until start; rerun passes.
